// File: rtl/bank_cmd_seq.sv
// Queues host read/write requests and turns them into single-cycle bank command pulses.
// Pulse 2 cycles after acceptance, 4-cycle turnaround; req_ready drops while the 2-entry queue is full.
module bank_cmd_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  // Readiness depends only on occupancy, so a same-cycle pop never frees a full slot.
  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = in_vld & in_rdy;
    pop      = out_vld & out_rdy;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module bank_cmd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       w_en,
  output logic       r_en,
  output logic [5:0] bank_addr,
  output logic [7:0] bank_wdata,
  input  logic       sa_en,
  input  logic [7:0] bank_rdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_data,
  output logic       busy
);
  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } req_t;

  typedef enum logic [2:0] {IDLE, WR_PULSE, WR_WAIT, RD_PULSE, RD_WAIT, GAP} state_t;

  req_t       req_dat, head_dat;
  logic       fifo_rdy, fifo_vld, pop;
  state_t     state_q, state_d;
  logic [2:0] tmo_q, tmo_d;
  logic       w_en_q, w_en_d, r_en_q, r_en_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [5:0] bank_addr_q, bank_addr_d;
  logic [7:0] bank_wdata_q, bank_wdata_d;

  assign req_dat = {req_we, req_addr, req_wdata};

  bank_cmd_fifo #(.W($bits(req_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (req_valid),
    .in_dat  (req_dat),
    .in_rdy  (fifo_rdy),
    .out_vld (fifo_vld),
    .out_dat (head_dat),
    .out_rdy (pop)
  );

  assign req_ready  = fifo_rdy & ~rst;
  assign busy       = fifo_vld | (state_q != IDLE);
  assign w_en       = w_en_q;
  assign r_en       = r_en_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    w_en_d       = 1'b0;
    r_en_d       = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_data_d   = rsp_data_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_vld) begin
          pop         = 1'b1;
          bank_addr_d = head_dat.addr;
          if (head_dat.we) begin
            bank_wdata_d = head_dat.wdata;
            w_en_d       = 1'b1;
            state_d      = WR_PULSE;
          end else begin
            r_en_d  = 1'b1;
            state_d = RD_PULSE;
          end
        end
      end
      WR_PULSE: state_d = WR_WAIT;
      WR_WAIT:  state_d = GAP;
      RD_PULSE: begin
        tmo_d   = 3'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Read data wins over a timeout landing in the same cycle.
        if (sa_en) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bank_rdata;
          tmo_d       = 3'd0;
          state_d     = GAP;
        end else if (tmo_q == 3'd7) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 8'h00;
          tmo_d       = 3'd0;
          state_d     = GAP;
        end else begin
          tmo_d = tmo_q + 3'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= 3'd0;
      w_en_q       <= 1'b0;
      r_en_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= 8'h00;
      bank_addr_q  <= 6'h00;
      bank_wdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      w_en_q       <= w_en_d;
      r_en_q       <= r_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
    end
  end
endmodule

// File: doc/bank_cmd_seq.md
BANK_CMD_SEQ -- requirements
Module: bank_cmd_seq

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1: host request present.
REQ-004 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-005 SHALL have port req_addr, input, 6: word address.
REQ-006 SHALL have port req_wdata, input, 8: write data (ignored for reads).
REQ-007 SHALL have port req_ready, output, 1: request accepted when req_valid & req_ready at clk edge.
REQ-008 SHALL have ports w_en and r_en, output, 1 each: single-cycle command pulses to the bank controller.
REQ-009 SHALL have ports bank_addr (6) and bank_wdata (8), output: operands driven to the bank.
REQ-010 SHALL have port sa_en, input, 1: bank sense-amp enable, marks valid read data.
REQ-011 SHALL have port bank_rdata, input, 8: bank read data, valid while sa_en = 1.
REQ-012 SHALL have ports rsp_valid (1), rsp_err (1) and rsp_data (8), output: read response.
REQ-013 SHALL have port busy, output, 1: FIFO non-empty or FSM not IDLE.

Function
REQ-014 SHALL buffer requests in a 2-entry FIFO {we, addr, wdata}; req_ready = FIFO not full.
REQ-015 SHALL not push when full, even if a pop occurs in the same cycle.
REQ-016 SHALL not bypass: a request pushed into an empty FIFO is popped no earlier than the next cycle.
REQ-017 SHALL implement FSM states IDLE, WR_PULSE, WR_WAIT, RD_PULSE, RD_WAIT, GAP.
REQ-018 SHALL leave IDLE only when the FIFO is non-empty, popping the head; next state is WR_PULSE if we = 1, else RD_PULSE.
REQ-019 SHALL assert w_en for exactly the WR_PULSE cycle, then go WR_WAIT (1 cycle, bank WRITE), then GAP.
REQ-020 SHALL assert r_en for exactly the RD_PULSE cycle, then go RD_WAIT.
REQ-021 RD_WAIT SHALL, in the first cycle with sa_en = 1, capture bank_rdata and pulse rsp_valid = 1 and rsp_err = 0 for 1 cycle; then go GAP.
REQ-022 RD_WAIT SHALL run a 3-bit timeout counter; if sa_en stays 0 for 8 cycles it SHALL pulse rsp_valid = 1, rsp_err = 1, rsp_data = 0x00, then go GAP.
REQ-023 GAP SHALL last 1 cycle (bank PRE recovery) and then go IDLE; w_en and r_en are 0 in every state except their pulse state.
REQ-024 Write turnaround SHALL be 4 cycles (IDLE, WR_PULSE, WR_WAIT, GAP); read turnaround SHALL be 4 cycles when sa_en comes on the first RD_WAIT cycle after RD_PULSE +1.
REQ-025 bank_addr and bank_wdata SHALL be registered at pop and held stable until the next pop; bank_wdata SHALL be unchanged by reads.
REQ-026 w_en and r_en SHALL never be high in the same cycle.
REQ-027 sa_en outside RD_WAIT SHALL be ignored, with no response generated.
REQ-028 rsp_valid SHALL be a 1-cycle pulse with no backpressure; rsp_data SHALL hold its last value afterwards.
REQ-029 Requests SHALL be executed strictly in acceptance order.

Reset
REQ-030 Asserting rst SHALL immediately force: state IDLE, FIFO empty, w_en = r_en = 0, rsp_valid = rsp_err = 0, rsp_data = 0, bank_addr = 0, bank_wdata = 0, timeout = 0, busy = 0.
REQ-031 While rst = 1, req_ready SHALL be 0; it becomes 1 in the first cycle after deassertion.
REQ-032 rst during any operation SHALL abort it; the in-flight request and any queued requests are discarded, with no response.

Verification
REQ-033 Single write addr = 0x05, data = 0xA5 -> w_en high exactly 1 cycle, 2 cycles after acceptance, with bank_addr = 0x05 and bank_wdata = 0xA5; busy low 4 cycles after pop.
REQ-034 Read addr = 0x12, bench drives sa_en for 1 cycle with bank_rdata = 0x3C on the 2nd RD_WAIT cycle -> rsp_valid pulse, rsp_data = 0x3C, rsp_err = 0.
REQ-035 Read with sa_en held 0 -> after 8 RD_WAIT cycles, rsp_valid = 1 and rsp_err = 1 with rsp_data = 0x00, then IDLE.
REQ-036 Three back-to-back requests W, R, W with req_valid held high -> req_ready drops after 2 are queued; operations execute in order; w_en and r_en are never simultaneous, and there is at least 1 GAP cycle between pulses.
REQ-037 rst asserted in RD_WAIT with 1 queued request -> r_en, w_en, rsp_valid and busy go low immediately; no response after release.
REQ-038 sa_en pulsed while IDLE -> no rsp_valid.
